// File: rtl/program_counter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : program_counter_if                                      |
// | Description : Control/data bundle between a sequencer (master) and     |
// |               the program counter (slave).                             |
// | Revision    : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
interface program_counter_if #(
    parameter int WIDTH = 16
);
    logic             load;
    logic             inc;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_err;

    modport master (
        output load, inc, push, pop, in,
        input  out, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  load, inc, push, pop, in,
        output out, stack_full, stack_empty, stack_err
    );
endinterface
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : program_counter                                         |
// | Description : Registered instruction address with load / increment,   |
// |               plus an optional call/return stack enabled by the macro  |
// |               PC_CALL_STACK_EN. Priority: reset > pop > push > load >  |
// |               inc > hold (pop/push absent without the macro).          |
// | Revision    : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
module program_counter #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    program_counter_if.slave pc_bus
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_pc_base;

    // Return address and increment share one adder; wrap is silent.
    assign w_pc_inc   = r_pc + WIDTH'(1);
    assign pc_bus.out = r_pc;

    // Non-stack next address: load beats inc, otherwise hold.
    always_comb begin
        w_pc_base = r_pc;
        if (pc_bus.load) begin
            w_pc_base = pc_bus.in;
        end else if (pc_bus.inc) begin
            w_pc_base = w_pc_inc;
        end
    end

`ifdef PC_CALL_STACK_EN
    // sp counts 0..STACK_DEPTH, so it needs one more code than the index.
    localparam int c_SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int c_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [WIDTH-1:0]   r_stack [STACK_DEPTH];
    logic [c_SP_W-1:0]  r_sp;
    logic               r_err;
    logic               w_full;
    logic               w_empty;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_do_push;

    assign w_full    = (r_sp == c_SP_W'(STACK_DEPTH));
    assign w_empty   = (r_sp == '0);
    assign w_wr_idx  = r_sp[c_IDX_W-1:0];
    assign w_rd_idx  = w_wr_idx - c_IDX_W'(1);
    // A simultaneous pop masks the push completely, including its error.
    assign w_do_push = pc_bus.push && !pc_bus.pop && !w_full;

    assign pc_bus.stack_full  = w_full;
    assign pc_bus.stack_empty = w_empty;
    assign pc_bus.stack_err   = r_err;

    // Address, stack pointer and sticky error update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= '0;
            r_sp  <= '0;
            r_err <= 1'b0;
        end else if (pc_bus.pop) begin
            if (!w_empty) begin
                r_pc <= r_stack[w_rd_idx];
                r_sp <= r_sp - c_SP_W'(1);
            end else begin
                r_err <= 1'b1;
            end
        end else if (pc_bus.push) begin
            r_pc <= pc_bus.in;
            if (!w_full) begin
                r_sp <= r_sp + c_SP_W'(1);
            end else begin
                r_err <= 1'b1;
            end
        end else begin
            r_pc <= w_pc_base;
        end
    end

    // Stack storage write; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && w_do_push) begin
            r_stack[w_wr_idx] <= w_pc_inc;
        end
    end
`else
    // Call/return controls and depth have no effect in this build.
    logic         unused_ctrl;
    localparam int unused_depth = STACK_DEPTH;

    assign unused_ctrl        = ^{pc_bus.push, pc_bus.pop, unused_depth[0]};
    assign pc_bus.stack_full  = 1'b0;
    assign pc_bus.stack_empty = 1'b1;
    assign pc_bus.stack_err   = 1'b0;

    // Address register: reset, else load/inc/hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_base;
        end
    end
`endif

endmodule
`default_nettype wire
